// File: rtl/sio_pad_ctrl_if.sv
// Configuration handshake bundle between the core and sio_pad_ctrl.
// The master offers a complete pad configuration with CFG_VALID. The slave
// accepts it with CFG_READY in the same cycle.
//   CFG_VALID / CFG_READY : offer / accept handshake
//   CFG_DM[2:0]           : drive mode
//   CFG_INP_DIS, CFG_SLOW, CFG_VTRIP_SEL, CFG_VREG_EN, CFG_IBUF_SEL,
//   CFG_HLD_OVR           : single-bit pad configuration fields
interface sio_pad_ctrl_if;
    logic       CFG_VALID;
    logic       CFG_READY;
    logic [2:0] CFG_DM;
    logic       CFG_INP_DIS;
    logic       CFG_SLOW;
    logic       CFG_VTRIP_SEL;
    logic       CFG_VREG_EN;
    logic       CFG_IBUF_SEL;
    logic       CFG_HLD_OVR;

    modport master (
        output CFG_VALID, CFG_DM, CFG_INP_DIS, CFG_SLOW, CFG_VTRIP_SEL,
               CFG_VREG_EN, CFG_IBUF_SEL, CFG_HLD_OVR,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID, CFG_DM, CFG_INP_DIS, CFG_SLOW, CFG_VTRIP_SEL,
               CFG_VREG_EN, CFG_IBUF_SEL, CFG_HLD_OVR,
        output CFG_READY
    );
endinterface

// File: rtl/sio_pad_ctrl.sv
// Core-side controller for one sky130 SIO pad.
// It sequences ENABLE_H and HLD_H_N so that the latched pad controls are
// stable before the pad latches open. It also handles hold entry and exit,
// with an optional output override, and it synchronizes the pad IN signal
// and produces edge pulses.
//   CLK, RESET         : clock, synchronous active-high reset
//   PWR_UP, HOLD_REQ   : level requests for power/enable and hold
//   cfg (slave)        : configuration handshake into the shadow register
//   DATA_OUT, DATA_OE  : core output data and output enable
//   ENABLE_H, HLD_H_N, DM, INP_DIS, SLOW, VTRIP_SEL, VREG_EN, IBUF_SEL,
//   HLD_OVR, OE_N, OUT : registered pad control pins
//   IN                 : asynchronous pad input
//   DATA_IN, RISE, FALL: synchronized input and one-cycle edge pulses
//   STATE              : current FSM state
module sio_pad_ctrl #(
    parameter int SETUP_CYC   = 4,
    parameter int HOLD_CYC    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                PWR_UP,
    input  logic                HOLD_REQ,
    sio_pad_ctrl_if.slave       cfg,
    input  logic                DATA_OUT,
    input  logic                DATA_OE,
    output logic                ENABLE_H,
    output logic                HLD_H_N,
    output logic [2:0]          DM,
    output logic                INP_DIS,
    output logic                SLOW,
    output logic                VTRIP_SEL,
    output logic                VREG_EN,
    output logic                IBUF_SEL,
    output logic                HLD_OVR,
    output logic                OE_N,
    output logic                OUT,
    input  logic                IN,
    output logic                DATA_IN,
    output logic                RISE,
    output logic                FALL,
    output logic [2:0]          STATE
);
    localparam int MAX_CYC = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_ENABLE     = 3'd1,
        ST_SETUP      = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_HOLD_ENTER = 3'd4,
        ST_HOLD       = 3'd5,
        ST_HOLD_EXIT  = 3'd6
    } state_t;

    typedef struct packed {
        logic [2:0] dm;
        logic       inp_dis;
        logic       slow;
        logic       vtrip_sel;
        logic       vreg_en;
        logic       ibuf_sel;
        logic       hld_ovr;
    } cfg_t;

    typedef struct packed {
        logic enable_h;
        logic hld_h_n;
        cfg_t c;
        logic oe_n;
        logic out;
    } pins_t;

    localparam cfg_t CFG_RST = '{dm: 3'b000, inp_dis: 1'b1, slow: 1'b0,
                                 vtrip_sel: 1'b0, vreg_en: 1'b0,
                                 ibuf_sel: 1'b0, hld_ovr: 1'b0};
    localparam pins_t PINS_RST = '{enable_h: 1'b0, hld_h_n: 1'b0, c: CFG_RST,
                                   oe_n: 1'b1, out: 1'b0};

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    cfg_t                   shadow_q, shadow_d;
    pins_t                  pins_q, pins_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   cfg_ready;
    logic                   qual;
    logic                   last;

    assign cfg_ready     = (state_q == ST_ACTIVE) && PWR_UP && !HOLD_REQ;
    assign cfg.CFG_READY = cfg_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;

        if (cfg.CFG_VALID && cfg_ready) begin
            shadow_d = '{dm: cfg.CFG_DM, inp_dis: cfg.CFG_INP_DIS,
                         slow: cfg.CFG_SLOW, vtrip_sel: cfg.CFG_VTRIP_SEL,
                         vreg_en: cfg.CFG_VREG_EN, ibuf_sel: cfg.CFG_IBUF_SEL,
                         hld_ovr: cfg.CFG_HLD_OVR};
        end

        // Power loss overrides every state. The shadow register is kept.
        if (!PWR_UP) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF:    state_d = ST_ENABLE;
                ST_ENABLE: begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                end
                ST_SETUP, ST_HOLD_EXIT: begin
                    if (cnt_q == '0) state_d = ST_ACTIVE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                ST_ACTIVE: begin
                    if (HOLD_REQ) begin
                        state_d = ST_HOLD_ENTER;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                ST_HOLD_ENTER: begin
                    if (cnt_q == '0) state_d = ST_HOLD;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                ST_HOLD: begin
                    if (!HOLD_REQ) begin
                        state_d = ST_HOLD_EXIT;
                        cnt_d   = SETUP_LOAD;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        // The pins are a function of the state being entered. This makes
        // HLD_H_N change on the same edge as the state transition.
        pins_d = PINS_RST;
        case (state_d)
            ST_ENABLE: pins_d.enable_h = 1'b1;
            ST_SETUP: begin
                pins_d.enable_h = 1'b1;
                pins_d.c        = shadow_d;
            end
            ST_ACTIVE: begin
                pins_d.enable_h = 1'b1;
                pins_d.hld_h_n  = 1'b1;
                pins_d.c        = shadow_d;
                pins_d.oe_n     = ~DATA_OE;
                pins_d.out      = DATA_OUT;
            end
            ST_HOLD_ENTER: pins_d = pins_q;
            ST_HOLD: begin
                pins_d         = pins_q;
                pins_d.hld_h_n = 1'b0;
                if (shadow_q.hld_ovr) begin
                    pins_d.oe_n = ~DATA_OE;
                    pins_d.out  = DATA_OUT;
                end
            end
            ST_HOLD_EXIT: begin
                pins_d.enable_h = 1'b1;
                pins_d.c        = shadow_d;
                pins_d.oe_n     = ~DATA_OE;
                pins_d.out      = DATA_OUT;
            end
            default: pins_d = PINS_RST;
        endcase

        // The input path runs only when the pad buffer is enabled. While
        // disqualified, the chain and prev are cleared, so qualification
        // starts from a known 0 and no spurious edge pulse is produced.
        qual   = ((state_q == ST_ACTIVE) || (state_q == ST_HOLD)) &&
                 !shadow_q.inp_dis && (shadow_q.dm != 3'b000);
        last   = sync_q[SYNC_STAGES-1];
        sync_d = qual ? {sync_q[SYNC_STAGES-2:0], IN} : '0;
        prev_d = qual && last;
        rise_d = qual && last && !prev_q;
        fall_d = qual && !last && prev_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            shadow_q <= CFG_RST;
            pins_q   <= PINS_RST;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            pins_q   <= pins_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign ENABLE_H  = pins_q.enable_h;
    assign HLD_H_N   = pins_q.hld_h_n;
    assign DM        = pins_q.c.dm;
    assign INP_DIS   = pins_q.c.inp_dis;
    assign SLOW      = pins_q.c.slow;
    assign VTRIP_SEL = pins_q.c.vtrip_sel;
    assign VREG_EN   = pins_q.c.vreg_en;
    assign IBUF_SEL  = pins_q.c.ibuf_sel;
    assign HLD_OVR   = pins_q.c.hld_ovr;
    assign OE_N      = pins_q.oe_n;
    assign OUT       = pins_q.out;
    assign DATA_IN   = sync_q[SYNC_STAGES-1];
    assign RISE      = rise_q;
    assign FALL      = fall_q;
    assign STATE     = state_q;
endmodule

// File: tb/tb_sio_pad_ctrl.sv
// Directed bench for sio_pad_ctrl using the default parameters
// (SETUP_CYC=4, HOLD_CYC=4, SYNC_STAGES=2).
module tb_sio_pad_ctrl;
    logic       CLK = 1'b0;
    logic       RESET, PWR_UP, HOLD_REQ, DATA_OUT, DATA_OE, IN;
    logic       ENABLE_H, HLD_H_N, INP_DIS, SLOW, VTRIP_SEL, VREG_EN;
    logic       IBUF_SEL, HLD_OVR, OE_N, OUT, DATA_IN, RISE, FALL;
    logic [2:0] DM, STATE;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    sio_pad_ctrl_if cfg_if ();

    sio_pad_ctrl dut (
        .CLK(CLK), .RESET(RESET), .PWR_UP(PWR_UP), .HOLD_REQ(HOLD_REQ),
        .cfg(cfg_if.slave), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
        .ENABLE_H(ENABLE_H), .HLD_H_N(HLD_H_N), .DM(DM), .INP_DIS(INP_DIS),
        .SLOW(SLOW), .VTRIP_SEL(VTRIP_SEL), .VREG_EN(VREG_EN),
        .IBUF_SEL(IBUF_SEL), .HLD_OVR(HLD_OVR), .OE_N(OE_N), .OUT(OUT),
        .IN(IN), .DATA_IN(DATA_IN), .RISE(RISE), .FALL(FALL), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       pwr, hreq, vld;
        logic [2:0] dm;
        logic       inp_dis, slow, ovr, dout, doe;
        logic       rdy;
        logic [2:0] st;
        logic       en, hld;
        logic [2:0] edm;
        logic       eslow, eoe_n, eout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic pwr, hreq, vld, input logic [2:0] dm,
                                input logic inp_dis, slow, ovr, dout, doe,
                                input logic rdy, input logic [2:0] st,
                                input logic en, hld, input logic [2:0] edm,
                                input logic eslow, eoe_n, eout);
        vec_t v;
        v.pwr = pwr; v.hreq = hreq; v.vld = vld; v.dm = dm;
        v.inp_dis = inp_dis; v.slow = slow; v.ovr = ovr;
        v.dout = dout; v.doe = doe; v.rdy = rdy; v.st = st;
        v.en = en; v.hld = hld; v.edm = edm;
        v.eslow = eslow; v.eoe_n = eoe_n; v.eout = eout;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_cfg(input logic vld, input logic [2:0] dm,
                             input logic inp_dis, slow, ovr);
        cfg_if.CFG_VALID   = vld;
        cfg_if.CFG_DM      = dm;
        cfg_if.CFG_INP_DIS = inp_dis;
        cfg_if.CFG_SLOW    = slow;
        cfg_if.CFG_HLD_OVR = ovr;
    endtask

    task automatic check_off(input string tag);
        check({tag, "_state"}, 8'(STATE), 8'd0);
        check({tag, "_enable_h"}, 8'(ENABLE_H), 8'd0);
        check({tag, "_hld_h_n"}, 8'(HLD_H_N), 8'd0);
        check({tag, "_oe_n"}, 8'(OE_N), 8'd1);
    endtask

    task automatic check_in(input string tag, input logic din, rise, fall);
        check({tag, "_data_in"}, 8'(DATA_IN), 8'(din));
        check({tag, "_rise"}, 8'(RISE), 8'(rise));
        check({tag, "_fall"}, 8'(FALL), 8'(fall));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; PWR_UP = 1'b0; HOLD_REQ = 1'b0;
        DATA_OUT = 1'b0; DATA_OE = 1'b0; IN = 1'b0;
        drive_cfg(L, 3'b000, L, L, L);
        cfg_if.CFG_VTRIP_SEL = 1'b0;
        cfg_if.CFG_VREG_EN   = 1'b0;
        cfg_if.CFG_IBUF_SEL  = 1'b0;
        step(); step();

        // Reset state
        check_off("rst");
        check("rst_dm", 8'(DM), 8'd0);
        check("rst_inp_dis", 8'(INP_DIS), 8'd1);
        check("rst_out_pins", {3'b0, OUT, SLOW, VTRIP_SEL, VREG_EN, IBUF_SEL}, 8'd0);
        check("rst_hld_ovr", 8'(HLD_OVR), 8'd0);
        check("rst_cfg_ready", 8'(cfg_if.CFG_READY), 8'd0);
        check_in("rst", L, L, L);
        RESET = 1'b0;

        // Fields: pwr,hreq,vld,dm,inp_dis,slow,ovr,dout,doe | rdy,st,en,hld,dm,slow,oe_n,out
        // Power-up: ENABLE after 1 cycle, 4 SETUP cycles, HLD_H_N=1 on the 6th edge
        vecs.push_back(mk(H,L,L,3'b000,H,L,L,L,L, L,3'd1,H,L,3'b000,L,H,L));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(H,L,L,3'b000,H,L,L,L,L, L,3'd2,H,L,3'b000,L,H,L));
        vecs.push_back(mk(H,L,L,3'b000,H,L,L,L,L, L,3'd3,H,H,3'b000,L,H,L));
        // Config accepted. Then an offer made together with HOLD_REQ is dropped.
        vecs.push_back(mk(H,L,H,3'b110,L,H,L,H,H, H,3'd3,H,H,3'b110,H,L,H));
        vecs.push_back(mk(H,H,H,3'b011,L,L,L,H,H, L,3'd4,H,H,3'b110,H,L,H));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(H,H,L,3'b000,H,L,L,H,H, L,3'd4,H,H,3'b110,H,L,H));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,H,H, L,3'd5,H,L,3'b110,H,L,H));
        // HOLD without override: OUT and OE_N stay frozen
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,L,H, L,3'd5,H,L,3'b110,H,L,H));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,L,L, L,3'd5,H,L,3'b110,H,L,H));
        // Exit: HOLD_EXIT drives live data, HOLD_REQ pulse is ignored, ACTIVE on the 5th edge
        vecs.push_back(mk(H,L,L,3'b000,H,L,L,L,H, L,3'd6,H,L,3'b110,H,L,L));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,H,H, L,3'd6,H,L,3'b110,H,L,H));
        vecs.push_back(mk(H,L,L,3'b000,H,L,L,L,H, L,3'd6,H,L,3'b110,H,L,L));
        vecs.push_back(mk(H,L,L,3'b000,H,L,L,H,H, L,3'd6,H,L,3'b110,H,L,H));
        vecs.push_back(mk(H,L,L,3'b000,H,L,L,L,H, L,3'd3,H,H,3'b110,H,L,L));
        vecs.push_back(mk(H,L,L,3'b000,H,L,L,H,H, H,3'd3,H,H,3'b110,H,L,H));
        // Hold with override
        vecs.push_back(mk(H,L,H,3'b110,L,H,H,H,H, H,3'd3,H,H,3'b110,H,L,H));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,H,H, L,3'd4,H,H,3'b110,H,L,H));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,H,H, L,3'd4,H,H,3'b110,H,L,H));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,L,H, L,3'd4,H,H,3'b110,H,L,H));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,H,H, L,3'd4,H,H,3'b110,H,L,H));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,L,H, L,3'd5,H,L,3'b110,H,L,L));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,H,H, L,3'd5,H,L,3'b110,H,L,H));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,L,L, L,3'd5,H,L,3'b110,H,H,L));
        vecs.push_back(mk(H,H,L,3'b000,H,L,L,H,H, L,3'd5,H,L,3'b110,H,L,H));

        foreach (vecs[i]) begin
            PWR_UP = vecs[i].pwr; HOLD_REQ = vecs[i].hreq;
            DATA_OUT = vecs[i].dout; DATA_OE = vecs[i].doe;
            drive_cfg(vecs[i].vld, vecs[i].dm, vecs[i].inp_dis, vecs[i].slow, vecs[i].ovr);
            #1;
            check($sformatf("row%0d_cfg_ready", i), 8'(cfg_if.CFG_READY), 8'(vecs[i].rdy));
            step();
            check($sformatf("row%0d_state", i), 8'(STATE), 8'(vecs[i].st));
            check($sformatf("row%0d_enable_h", i), 8'(ENABLE_H), 8'(vecs[i].en));
            check($sformatf("row%0d_hld_h_n", i), 8'(HLD_H_N), 8'(vecs[i].hld));
            check($sformatf("row%0d_dm", i), 8'(DM), 8'(vecs[i].edm));
            check($sformatf("row%0d_slow", i), 8'(SLOW), 8'(vecs[i].eslow));
            check($sformatf("row%0d_oe_n", i), 8'(OE_N), 8'(vecs[i].eoe_n));
            check($sformatf("row%0d_out", i), 8'(OUT), 8'(vecs[i].eout));
        end
        drive_cfg(L, 3'b000, H, L, L);

        // RESET while in HOLD
        RESET = 1'b1;
        step();
        check_off("rst_in_hold");
        RESET = 1'b0; PWR_UP = 1'b0; HOLD_REQ = 1'b0;
        step();

        // Power loss during SETUP
        PWR_UP = 1'b1;
        step(); step(); step();
        check("abort_setup_pre", 8'(STATE), 8'd2);
        PWR_UP = 1'b0;
        step();
        check_off("abort_setup");

        // Power loss during HOLD_ENTER, then confirm the shadow is retained
        PWR_UP = 1'b1;
        repeat (6) step();
        check("pu2_state", 8'(STATE), 8'd3);
        check("pu2_hld_h_n", 8'(HLD_H_N), 8'd1);
        drive_cfg(H, 3'b110, L, L, L);
        step();
        check("cfg2_dm", 8'(DM), 8'd6);
        drive_cfg(L, 3'b000, H, L, L);
        HOLD_REQ = 1'b1;
        step(); step();
        check("abort_he_pre", 8'(STATE), 8'd4);
        PWR_UP = 1'b0;
        step();
        check_off("abort_hold_enter");
        check("abort_he_dm", 8'(DM), 8'd0);
        HOLD_REQ = 1'b0; PWR_UP = 1'b1;
        step(); step();
        check("retain_state", 8'(STATE), 8'd2);
        check("retain_dm", 8'(DM), 8'd6);
        repeat (4) step();
        check("retain_active", 8'(STATE), 8'd3);

        // Input path: DM=110, INP_DIS=0
        step(); step();
        check_in("in_idle", L, L, L);
        IN = 1'b1;
        step(); check_in("in_r1", L, L, L);
        step(); check_in("in_r2", H, L, L);
        step(); check_in("in_r3", H, H, L);
        step(); check_in("in_r4", H, L, L);
        step();
        IN = 1'b0;
        step(); check_in("in_f1", H, L, L);
        step(); check_in("in_f2", L, L, L);
        step(); check_in("in_f3", L, L, H);
        step(); check_in("in_f4", L, L, L);

        // Input buffer disabled: the path stays at 0
        drive_cfg(H, 3'b110, H, L, L);
        #1;
        check("dis_cfg_ready", 8'(cfg_if.CFG_READY), 8'd1);
        step();
        drive_cfg(L, 3'b000, H, L, L);
        check("dis_inp_dis_pin", 8'(INP_DIS), 8'd1);
        IN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_in($sformatf("dis%0d", i), L, L, L);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
